// File: rtl/power_job_arbiter.sv
// Round-robin front end that time-shares one A^B exponentiation engine between NREQ requesters,
// launching each granted job and aborting it if the engine fails to acknowledge or finish in time.
module power_job_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int ACK_LIMIT = 4,
    parameter int RUN_LIMIT = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*DW-1:0] req_a_i,
    input  logic [NREQ*DW-1:0] req_b_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    done_o,
    output logic [DW-1:0]      result_o,
    output logic               err_o,
    output logic [2:0]         err_id_o,
    output logic               eng_start_o,
    output logic [DW-1:0]      eng_a_o,
    output logic [DW-1:0]      eng_b_o,
    input  logic               eng_busy_i,
    input  logic [DW-1:0]      eng_result_i
);

    localparam int CW = 20;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, RUN, SETTLE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [2:0]      ptr_q, ptr_d;
    logic            mask_q, mask_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   result_q, result_d;
    logic            err_q, err_d;
    logic [2:0]      err_id_q, err_id_d;
    logic            start_q, start_d;
    logic [DW-1:0]   eng_a_q, eng_a_d;
    logic [DW-1:0]   eng_b_q, eng_b_d;

    logic [NREQ-1:0] req_m;
    logic            found;
    logic [2:0]      win;
    logic [DW-1:0]   win_a, win_b;
    logic            abort, finish;
    logic [2:0]      ptr_nxt;

    assign ptr_nxt = (idx_q == 3'(NREQ - 1)) ? 3'd0 : idx_q + 3'd1;

    // Search from ptr upward with wrap: first pass covers ptr..NREQ-1, second pass 0..ptr-1.
    always_comb begin
        req_m = req_i;
        for (int k = 0; k < NREQ; k++)
            if (mask_q && idx_q == 3'(k)) req_m[k] = 1'b0;
        found = 1'b0;
        win   = '0;
        win_a = '0;
        win_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_m[k] && 3'(k) >= ptr_q) begin
                found = 1'b1;
                win   = 3'(k);
                win_a = req_a_i[k*DW +: DW];
                win_b = req_b_i[k*DW +: DW];
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_m[k] && 3'(k) < ptr_q) begin
                found = 1'b1;
                win   = 3'(k);
                win_a = req_a_i[k*DW +: DW];
                win_b = req_b_i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!eng_busy_i && found) state_d = LAUNCH;
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (eng_busy_i) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(ACK_LIMIT)) abort = 1'b1;
                end
            end
            RUN: begin
                if (!eng_busy_i) begin
                    state_d = SETTLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(RUN_LIMIT)) abort = 1'b1;
                end
            end
            SETTLE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // The engine's output register is only valid one cycle after busy falls, hence capture on SETTLE exit.
    always_comb begin
        gnt_d    = gnt_q;
        done_d   = '0;
        result_d = result_q;
        err_d    = 1'b0;
        err_id_d = err_id_q;
        start_d  = 1'b0;
        eng_a_d  = eng_a_q;
        eng_b_d  = eng_b_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        mask_d   = 1'b0;
        if (state_q == IDLE && state_d == LAUNCH) begin
            idx_d   = win;
            eng_a_d = win_a;
            eng_b_d = win_b;
            start_d = 1'b1;
            for (int k = 0; k < NREQ; k++) gnt_d[k] = (win == 3'(k));
        end
        if (finish) begin
            result_d = eng_result_i;
            for (int k = 0; k < NREQ; k++) done_d[k] = (idx_q == 3'(k));
            gnt_d  = '0;
            ptr_d  = ptr_nxt;
            mask_d = 1'b1;
        end
        if (abort) begin
            err_d    = 1'b1;
            err_id_d = idx_q;
            gnt_d    = '0;
            ptr_d    = ptr_nxt;
            mask_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            mask_q   <= 1'b0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
            start_q  <= 1'b0;
            eng_a_q  <= '0;
            eng_b_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
            start_q  <= start_d;
            eng_a_q  <= eng_a_d;
            eng_b_q  <= eng_b_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign err_o       = err_q;
    assign err_id_o    = err_id_q;
    assign eng_start_o = start_q;
    assign eng_a_o     = eng_a_q;
    assign eng_b_o     = eng_b_q;

endmodule
